// File: rtl/div_req_sequencer_if.sv
// Bundle of the request, divider and result handshakes around div_req_sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface div_req_sequencer_if #(
    parameter int N     = 64,
    parameter int M     = 64,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_dividend;
    logic [N-1:0]     in_divisor;
    logic [TAG_W-1:0] in_tag;

    logic             div_start;
    logic [N-1:0]     div_dividend;
    logic [N-1:0]     div_divisor;
    logic [N-1:0]     div_quotient;
    logic [M-1:0]     div_remainder;
    logic             div_done;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_quotient;
    logic [M-1:0]     out_remainder;
    logic [TAG_W-1:0] out_tag;
    logic             out_div0;
    logic             out_err;

    logic [CW-1:0]    fifo_count;

    modport slave (
        input  in_valid, in_dividend, in_divisor, in_tag,
        input  div_quotient, div_remainder, div_done,
        input  out_ready,
        output in_ready,
        output div_start, div_dividend, div_divisor,
        output out_valid, out_quotient, out_remainder, out_tag, out_div0, out_err,
        output fifo_count
    );

    modport master (
        output in_valid, in_dividend, in_divisor, in_tag,
        output div_quotient, div_remainder, div_done,
        output out_ready,
        input  in_ready,
        input  div_start, div_dividend, div_divisor,
        input  out_valid, out_quotient, out_remainder, out_tag, out_div0, out_err,
        input  fifo_count
    );
endinterface

// File: rtl/div_req_sequencer.sv
// Request FIFO + issue FSM in front of div_module: one divide in flight,
// local divide-by-zero handling and a timeout escape for a hung divider.
module div_req_sequencer #(
    parameter int N       = 64,
    parameter int M       = 64,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    div_req_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic [N-1:0]     dvd;
        logic [N-1:0]     dvs;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    req_t          mem [DEPTH];
    req_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;

    state_t           state;
    logic [TW-1:0]    wcnt;
    logic [TAG_W-1:0] cur_tag;

    // full looks at the current count only, so a same-cycle pop never frees a slot early
    assign full           = (count == CW'(DEPTH));
    assign empty          = (count == '0);
    assign push           = bus.in_valid && !full;
    assign pop            = (state == IDLE) && !empty;
    assign head           = mem[rd_ptr];
    assign bus.in_ready   = !full;
    assign bus.fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{dvd: bus.in_dividend, dvs: bus.in_divisor, tag: bus.in_tag};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            wcnt              <= '0;
            cur_tag           <= '0;
            bus.div_start     <= 1'b0;
            bus.div_dividend  <= '0;
            bus.div_divisor   <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_quotient  <= '0;
            bus.out_remainder <= '0;
            bus.out_tag       <= '0;
            bus.out_div0      <= 1'b0;
            bus.out_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    cur_tag <= head.tag;
                    if (head.dvs == '0) begin
                        bus.out_quotient  <= '1;
                        bus.out_remainder <= M'(head.dvd);
                        bus.out_tag       <= head.tag;
                        bus.out_div0      <= 1'b1;
                        bus.out_err       <= 1'b0;
                        bus.out_valid     <= 1'b1;
                        state             <= HOLD;
                    end else begin
                        bus.div_dividend <= head.dvd;
                        bus.div_divisor  <= head.dvs;
                        bus.div_start    <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.div_start <= 1'b0;
                    wcnt          <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    // wcnt==0 is the guard cycle: a done level left over from the last op is ignored
                    if (wcnt != '0 && bus.div_done) begin
                        bus.out_quotient  <= bus.div_quotient;
                        bus.out_remainder <= bus.div_remainder;
                        bus.out_tag       <= cur_tag;
                        bus.out_div0      <= 1'b0;
                        bus.out_err       <= 1'b0;
                        bus.out_valid     <= 1'b1;
                        state             <= HOLD;
                    end else if (wcnt == TO_LAST) begin
                        bus.out_quotient  <= '0;
                        bus.out_remainder <= '0;
                        bus.out_tag       <= cur_tag;
                        bus.out_div0      <= 1'b0;
                        bus.out_err       <= 1'b1;
                        bus.out_valid     <= 1'b1;
                        state             <= HOLD;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                HOLD: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed bench for div_req_sequencer with a behavioural divider stub whose
// done level stays high after completion and whose result only updates on done.
module tb_div_req_sequencer;
    localparam int N = 64, M = 64, DEPTH = 4, TAG_W = 4, TIMEOUT = 255;
    localparam int BOUND = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_req_sequencer_if #(.N(N), .M(M), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    div_req_sequencer #(.N(N), .M(M), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // divider stub: done rises lat edges after start is sampled, drops one edge after the next start
    int          st_lat  = 2;
    bit          st_hang = 1'b0;
    int          scnt    = 0;
    logic [63:0] sq = '0, sr = '0;
    logic        stub_done = 1'b0;
    logic [63:0] stub_q = '0, stub_r = '0;

    assign bus.div_done      = stub_done;
    assign bus.div_quotient  = stub_q;
    assign bus.div_remainder = stub_r;

    always @(posedge clk) begin
        if (bus.div_start) begin
            sq   <= bus.div_dividend / bus.div_divisor;
            sr   <= bus.div_dividend % bus.div_divisor;
            scnt <= st_lat;
        end else if (scnt > 1) begin
            scnt      <= scnt - 1;
            stub_done <= 1'b0;
        end else if (scnt == 1) begin
            scnt <= 0;
            if (!st_hang) begin
                stub_done <= 1'b1;
                stub_q    <= sq;
                stub_r    <= sr;
            end
        end
    end

    typedef struct {
        logic [63:0] dvd;
        logic [63:0] dvs;
        logic [3:0]  tag;
        int          lat;
        bit          hang;
        logic [63:0] eq;
        logic [63:0] er;
        bit          ediv0;
        bit          eerr;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n, output int starts);
        n = 0;
        starts = 0;
        while (!bus.out_valid && n < BOUND) begin
            tick();
            n++;
            if (bus.div_start) starts++;
        end
        chk("out_valid_arrives", bus.out_valid, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        int n, starts;
        st_lat  = v.lat;
        st_hang = v.hang;
        bus.in_valid    = 1'b1;
        bus.in_dividend = v.dvd;
        bus.in_divisor  = v.dvs;
        bus.in_tag      = v.tag;
        chk("in_ready_idle", bus.in_ready, 1'b1);
        tick();                                   // edge T: accepted
        bus.in_valid = 1'b0;
        chk("fifo_count_after_push", bus.fifo_count, 1);
        chk("out_valid_low_at_T", bus.out_valid, 1'b0);
        tick();                                   // edge T+1: popped by IDLE
        if (v.ediv0) begin
            chk("div0_out_valid_T2", bus.out_valid, 1'b1);
            chk("div0_no_start", bus.div_start, 1'b0);
        end else begin
            chk("div_start_T2", bus.div_start, 1'b1);
            chk("div_dividend", bus.div_dividend, v.dvd);
            chk("div_divisor", bus.div_divisor, v.dvs);
            tick();
            chk("div_start_one_pulse", bus.div_start, 1'b0);
            wait_valid(n, starts);
            chk("extra_starts", starts, 0);
            chk("latency_from_wait", n, v.hang ? TIMEOUT : v.lat + 1);
            chk("operands_held", bus.div_dividend, v.dvd);
        end
        chk("out_quotient", bus.out_quotient, v.eq);
        chk("out_remainder", bus.out_remainder, v.er);
        chk("out_tag", bus.out_tag, v.tag);
        chk("out_div0", bus.out_div0, v.ediv0);
        chk("out_err", bus.out_err, v.eerr);
        tick();                                   // held while out_ready=0
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_quotient", bus.out_quotient, v.eq);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("valid_drop_after_ready", bus.out_valid, 1'b0);
        chk("fifo_empty_after_op", bus.fifo_count, 0);
    endtask

    initial begin
        logic [63:0] bp_q [5];
        logic [63:0] bp_r [5];
        int n, starts, seen;

        bus.in_valid = 1'b0; bus.in_dividend = '0; bus.in_divisor = '0; bus.in_tag = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{64'd100, 64'd7, 4'd3, 10, 1'b0, 64'd14, 64'd2, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hF, 4'd9, 20, 1'b0, 64'h1111_1111_1111_1111, 64'd0, 1'b0, 1'b0};
        vecs[2] = '{64'h1234, 64'd0, 4'd5, 2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1'b0};
        vecs[3] = '{64'd1000, 64'd10, 4'd7, 5, 1'b1, 64'd0, 64'd0, 1'b0, 1'b1};
        vecs[4] = '{64'd17, 64'd5, 4'd2, 3, 1'b0, 64'd3, 64'd2, 1'b0, 1'b0};
        vecs[5] = '{64'd5, 64'd9, 4'hF, 4, 1'b0, 64'd0, 64'd5, 1'b0, 1'b0};
        bp_q = '{64'd33, 64'd33, 64'd34, 64'd34, 64'd34};
        bp_r = '{64'd1, 64'd2, 64'd0, 64'd1, 64'd2};

        // reset state
        tick(); tick();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_div_start", bus.div_start, 1'b0);
        chk("rst_div_dividend", bus.div_dividend, 64'd0);
        chk("rst_div_divisor", bus.div_divisor, 64'd0);
        chk("rst_out_quotient", bus.out_quotient, 64'd0);
        chk("rst_out_remainder", bus.out_remainder, 64'd0);
        chk("rst_out_flags", {bus.out_tag, bus.out_div0, bus.out_err}, 64'd0);
        #2 rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // backpressure: 1 op in the FSM plus 4 queued, sixth push refused
        st_lat = 2; st_hang = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid    = 1'b1;
            bus.in_dividend = 64'd100 + 64'(i);
            bus.in_divisor  = 64'd3;
            bus.in_tag      = 4'(i);
            chk("bp_in_ready", bus.in_ready, (i < 5));
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_fifo_count_full", bus.fifo_count, 4);
        for (int k = 0; k < 5; k++) begin
            wait_valid(n, starts);
            chk("bp_tag_order", bus.out_tag, 64'(k));
            chk("bp_quotient", bus.out_quotient, bp_q[k]);
            chk("bp_remainder", bus.out_remainder, bp_r[k]);
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            if (k == 0) begin
                chk("bp_in_ready_before_pop", bus.in_ready, 1'b0);
                tick();
                chk("bp_in_ready_after_pop", bus.in_ready, 1'b1);
            end
        end
        chk("bp_fifo_drained", bus.fifo_count, 0);

        // reset while the divider hangs in WAIT with two requests queued
        st_hang = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid    = 1'b1;
            bus.in_dividend = 64'd50 + 64'(i);
            bus.in_divisor  = 64'd4;
            bus.in_tag      = 4'(8 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_wait_queued", bus.fifo_count, 2);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_fifo_count", bus.fifo_count, 0);
        chk("async_rst_out_valid", bus.out_valid, 1'b0);
        chk("async_rst_div_start", bus.div_start, 1'b0);
        chk("async_rst_in_ready", bus.in_ready, 1'b1);
        #2 rst = 1'b1;
        st_hang = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (bus.out_valid || bus.div_start) seen++;
        end
        bus.out_ready = 1'b0;
        chk("no_result_after_reset", seen, 0);
        chk("fifo_empty_after_reset", bus.fifo_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
